inst_encoder_loader: RTL and testbench
======================================

Name: inst_encoder_loader

Overview:
- Streaming RV32 instruction encoder and loader.
- Accepts decoded instruction records: mnemonic code, register indices and a signed immediate.
- Packs each record into the 32-bit machine word that the CPU control decoder consumes.
- Presents each word with an auto-incrementing word address to the instruction-memory write port. This is the inverse of the control/decode path and is used by the program loader and testbenches to fill instruction memory.

Parameters:
- ADDR_W, 8, instruction-memory word-address width.
- BASE_ADDR, 0, first word address after start.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a new program load.
- in_valid  in  1  input record valid.
- in_ready  out  1  record accepted when in_valid && in_ready.
- in_op  in  4  mnemonic code: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 ADDI, 5 ANDI, 6 ORI, 7 LW, 8 SW, 9 BEQ; 10–15 illegal.
- in_rd  in  5  destination register.
- in_rs1  in  5  source register 1.
- in_rs2  in  5  source register 2.
- in_imm  in  13  signed immediate; byte offset for BEQ.
- in_last  in  1  marks the final record of the program.
- out_valid  out  1  encoded word valid.
- out_ready  in  1  memory writer accepts the word.
- out_inst  out  32  encoded instruction.
- out_addr  out  ADDR_W  word address for out_inst.
- err  out  1  sticky error flag.
- done  out  1  high in DONE state.

Behaviour:
- Reset: state IDLE; out_valid=0, out_inst=0, out_addr=BASE_ADDR, err=0, done=0, in_ready=0.
- States: IDLE, RUN, DRAIN, DONE.
  - IDLE -> RUN on start.
  - RUN -> DRAIN on accepting a record with in_last=1.
  - DRAIN -> DONE when the output register is empty.
  - DONE -> RUN on start.
  - start in RUN or DRAIN is ignored.
- Start action: entering RUN from start sets out_addr=BASE_ADDR and clears err and done.
- Reset mid-load: abandons any pending word; all outputs return to reset values.
- Output register: single stage, one word.
  - in_ready = (state==RUN) && (!out_valid || out_ready), giving full throughput.
  - Latency is 1 cycle from accept to out_valid.
  - out_inst and out_addr are held stable while out_valid && !out_ready.
- Address: out_addr increments by 1 after each out handshake and wraps modulo 2^ADDR_W.
  - A handshake at address 2^ADDR_W-1 whose word is not the last sets err.
- Encoding. Fields not used by a format are zero, and ignored inputs do not affect the word.
  - R (ADD/SUB/AND/OR): funct7|rs2|rs1|funct3|rd|0110011. funct3 is 000/000/111/110; funct7 is 0100000 for SUB, otherwise 0.
  - I-ALU (ADDI/ANDI/ORI): imm[11:0]|rs1|funct3|rd|0010011. funct3 is 000/111/110.
  - LW: imm[11:0]|rs1|010|rd|0000011.
  - SW: imm[11:5]|rs2|rs1|010|imm[4:0]|0100011.
  - BEQ: imm[12]|imm[10:5]|rs2|rs1|000|imm[4:1]|imm[11]|1100011.
- Errors. Any error record is consumed (handshake completes), no word is emitted, the address does not advance, and err is set.
  - Illegal op.
  - I/S immediate outside [-2048, 2047].
  - BEQ immediate odd.
  - An erroneous record with in_last=1 still moves the state to DRAIN.
- err holds until start or rst.

Decomposition:
- Shared package holds:
  - mnemonic code constants;
  - opcode constants 0110011, 0010011, 0000011, 0100011, 1100011;
  - funct3/funct7 constants;
  - state encoding.
- One natural combinational sub-module, inst_pack: takes op, rd, rs1, rs2 and imm, and produces the 32-bit word plus an illegal flag. The top level owns the FSM, handshake, address counter and err.

Test Plan:
- start; ADD rd=3 rs1=1 rs2=2 -> out_inst=0x002081B3, out_addr=0.
- Back-to-back, out_ready=1: SUB 5,6,7; ADDI 1,0,5; LW 4,8(x2) -> 0x407302B3, 0x00500093, 0x00812203 at addr 0,1,2 on consecutive cycles.
- SW rs2=5, rs1=1, imm=-4 -> 0xFE50AE23. BEQ rs1=1, rs2=2, imm=-8 with in_last=1 -> 0xFE208CE3, then done=1.
- out_ready held low 3 cycles with a word pending -> out_inst/out_addr stable, in_ready=0, no record lost.
- in_op=12, then ADDI imm=3000, then BEQ imm=5 -> err=1, no out_valid, out_addr unchanged. The next valid ADD is emitted at the same address.
- ADDR_W=2, five non-last records -> addresses 0,1,2,3,0 and err set on the fourth handshake. rst mid-stream -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/inst_encoder_loader_pkg.sv
// Shared constants for the RV32 instruction encoder/loader: mnemonic codes,
// base opcodes, funct fields and the loader state encoding.
package inst_encoder_loader_pkg;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_ADDI = 4'd4;
    localparam logic [3:0] OP_ANDI = 4'd5;
    localparam logic [3:0] OP_ORI  = 4'd6;
    localparam logic [3:0] OP_LW   = 4'd7;
    localparam logic [3:0] OP_SW   = 4'd8;
    localparam logic [3:0] OP_BEQ  = 4'd9;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_IALU   = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_AND = 3'b111;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_SW  = 3'b010;
    localparam logic [2:0] F3_BEQ = 3'b000;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_SUB  = 7'b0100000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_t;

    // A 13-bit value fits a 12-bit signed field when its top two bits agree.
    function automatic logic fits_imm12(input logic signed [12:0] imm);
        return imm[12] == imm[11];
    endfunction

endpackage

// File: rtl/inst_encoder_loader_pack.sv
// Combinational packer: one decoded record in, one RV32 machine word out,
// plus a flag for records that have no legal encoding.
module inst_pack
    import inst_encoder_loader_pkg::*;
(
    input  logic        [3:0]  op,
    input  logic        [4:0]  rd,
    input  logic        [4:0]  rs1,
    input  logic        [4:0]  rs2,
    input  logic signed [12:0] imm,
    output logic        [31:0] inst,
    output logic               illegal
);

    always_comb begin
        inst    = '0;
        illegal = 1'b0;
        case (op)
            OP_ADD:  inst = {F7_BASE, rs2, rs1, F3_ADD, rd, OPC_R};
            OP_SUB:  inst = {F7_SUB,  rs2, rs1, F3_ADD, rd, OPC_R};
            OP_AND:  inst = {F7_BASE, rs2, rs1, F3_AND, rd, OPC_R};
            OP_OR:   inst = {F7_BASE, rs2, rs1, F3_OR,  rd, OPC_R};
            OP_ADDI: begin
                inst    = {imm[11:0], rs1, F3_ADD, rd, OPC_IALU};
                illegal = !fits_imm12(imm);
            end
            OP_ANDI: begin
                inst    = {imm[11:0], rs1, F3_AND, rd, OPC_IALU};
                illegal = !fits_imm12(imm);
            end
            OP_ORI: begin
                inst    = {imm[11:0], rs1, F3_OR, rd, OPC_IALU};
                illegal = !fits_imm12(imm);
            end
            OP_LW: begin
                inst    = {imm[11:0], rs1, F3_LW, rd, OPC_LOAD};
                illegal = !fits_imm12(imm);
            end
            OP_SW: begin
                inst    = {imm[11:5], rs2, rs1, F3_SW, imm[4:0], OPC_STORE};
                illegal = !fits_imm12(imm);
            end
            OP_BEQ: begin
                // Branch targets are halfword aligned, so imm[0] is not encoded.
                inst    = {imm[12], imm[10:5], rs2, rs1, F3_BEQ, imm[4:1], imm[11], OPC_BRANCH};
                illegal = imm[0];
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/inst_encoder_loader.sv
// Streaming loader: packs decoded records into RV32 words and presents them
// with an auto-incrementing word address to the instruction-memory writer.
module inst_encoder_loader
    import inst_encoder_loader_pkg::*;
#(
    parameter int          ADDR_W    = 8,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic        [3:0]  in_op,
    input  logic        [4:0]  in_rd,
    input  logic        [4:0]  in_rs1,
    input  logic        [4:0]  in_rs2,
    input  logic signed [12:0] in_imm,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic        [31:0] out_inst,
    output logic [ADDR_W-1:0]  out_addr,
    output logic               err,
    output logic               done
);

    localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

    state_t      state;
    logic [31:0] pack_inst_p0;
    logic        pack_illegal_p0;
    logic        last_p1;
    logic        accept;
    logic        out_fire;

    inst_pack u_pack (
        .op      (in_op),
        .rd      (in_rd),
        .rs1     (in_rs1),
        .rs2     (in_rs2),
        .imm     (in_imm),
        .inst    (pack_inst_p0),
        .illegal (pack_illegal_p0)
    );

    assign in_ready = (state == ST_RUN) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    // p0 -> p1: packed word lands in the single output register
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
            out_inst  <= '0;
            out_addr  <= BASE;
            last_p1   <= 1'b0;
            err       <= 1'b0;
            done      <= 1'b0;
        end else begin
            if (out_fire) begin
                out_valid <= 1'b0;
                out_addr  <= out_addr + ADDR_W'(1);
                if (out_addr == ADDR_MAX && !last_p1)
                    err <= 1'b1;
            end

            if (accept) begin
                if (pack_illegal_p0) begin
                    err <= 1'b1;
                end else begin
                    out_valid <= 1'b1;
                    out_inst  <= pack_inst_p0;
                    last_p1   <= in_last;
                end
            end

            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state    <= ST_RUN;
                        out_addr <= BASE;
                        err      <= 1'b0;
                        done     <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (accept && in_last)
                        state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (!out_valid) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_inst_encoder_loader.sv
// Directed bench for inst_encoder_loader: a default-width instance for the
// encoding/handshake scenarios and a 2-bit-address instance for wrap-around.
module tb_inst_encoder_loader;

    logic               clk = 1'b0;
    logic               rst, rst2, start, start2;
    logic               in_valid, in_last, out_ready;
    logic        [3:0]  in_op;
    logic        [4:0]  in_rd, in_rs1, in_rs2;
    logic signed [12:0] in_imm;

    logic        in_ready, out_valid, err, done;
    logic [31:0] out_inst;
    logic [7:0]  out_addr;
    logic        in_ready2, out_valid2, err2, done2;
    logic [31:0] out_inst2;
    logic [1:0]  out_addr2;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    inst_encoder_loader #(.ADDR_W(8), .BASE_ADDR(0)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
        .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
        .out_inst(out_inst), .out_addr(out_addr), .err(err), .done(done)
    );

    inst_encoder_loader #(.ADDR_W(2), .BASE_ADDR(0)) dut2 (
        .clk(clk), .rst(rst2), .start(start2), .in_valid(in_valid), .in_ready(in_ready2),
        .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
        .in_last(in_last), .out_valid(out_valid2), .out_ready(out_ready),
        .out_inst(out_inst2), .out_addr(out_addr2), .err(err2), .done(done2)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic signed [12:0] imm, input logic last);
        in_valid = 1'b1;
        in_op    = op;
        in_rd    = rd;
        in_rs1   = rs1;
        in_rs2   = rs2;
        in_imm   = imm;
        in_last  = last;
    endtask

    task automatic idle_in;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic pulse_start;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int k = 0;
        while (done !== 1'b1 && k < 20) begin
            step();
            k++;
        end
        n_checks++;
        if (done !== 1'b1) begin n_fail++; $display("FAIL %s_done: done=%b expected 1 within 20 cycles", tag, done); end
    endtask

    task automatic test_reset;
        rst = 1'b1; rst2 = 1'b1; start = 1'b0; start2 = 1'b0; out_ready = 1'b1;
        idle_in();
        in_op = 4'd0; in_rd = 5'd0; in_rs1 = 5'd0; in_rs2 = 5'd0; in_imm = 13'sd0;
        step(); step();
        rst = 1'b0; rst2 = 1'b0;
        step();
        n_checks += 6;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
        if (out_inst !== 32'h0) begin n_fail++; $display("FAIL reset_inst: got %h expected 0", out_inst); end
        if (out_addr !== 8'h00) begin n_fail++; $display("FAIL reset_addr: got %h expected 00", out_addr); end
        if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", err); end
        if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b expected 0", in_ready); end
    endtask

    task automatic test_single;
        pulse_start();
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL single_ready: got %b expected 1", in_ready); end
        send(4'd0, 5'd3, 5'd1, 5'd2, 13'sd0, 1'b1);
        step();
        idle_in();
        n_checks += 4;
        if (out_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %b expected 1", out_valid); end
        if (out_inst !== 32'h002081B3) begin n_fail++; $display("FAIL single_inst: got %h expected 002081b3", out_inst); end
        if (out_addr !== 8'h00) begin n_fail++; $display("FAIL single_addr: got %h expected 00", out_addr); end
        if (done !== 1'b0) begin n_fail++; $display("FAIL single_early_done: got %b expected 0", done); end
        wait_done("single");
        n_checks += 2;
        if (out_addr !== 8'h01) begin n_fail++; $display("FAIL single_addr_after: got %h expected 01", out_addr); end
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_valid_after: got %b expected 0", out_valid); end
    endtask

    task automatic test_back_to_back;
        pulse_start();
        n_checks += 2;
        if (out_addr !== 8'h00) begin n_fail++; $display("FAIL b2b_start_addr: got %h expected 00", out_addr); end
        if (done !== 1'b0) begin n_fail++; $display("FAIL b2b_start_done: got %b expected 0", done); end
        send(4'd1, 5'd5, 5'd6, 5'd7, 13'sd0, 1'b0);
        step();
        n_checks += 3;
        if (out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_sub_valid: got %b expected 1", out_valid); end
        if (out_inst !== 32'h407302B3) begin n_fail++; $display("FAIL b2b_sub_inst: got %h expected 407302b3", out_inst); end
        if (out_addr !== 8'h00) begin n_fail++; $display("FAIL b2b_sub_addr: got %h expected 00", out_addr); end
        send(4'd4, 5'd1, 5'd0, 5'd31, 13'sd5, 1'b0);
        step();
        n_checks += 3;
        if (out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_addi_valid: got %b expected 1", out_valid); end
        if (out_inst !== 32'h00500093) begin n_fail++; $display("FAIL b2b_addi_inst: got %h expected 00500093", out_inst); end
        if (out_addr !== 8'h01) begin n_fail++; $display("FAIL b2b_addi_addr: got %h expected 01", out_addr); end
        send(4'd7, 5'd4, 5'd2, 5'd9, 13'sd8, 1'b0);
        step();
        n_checks += 2;
        if (out_inst !== 32'h00812203) begin n_fail++; $display("FAIL b2b_lw_inst: got %h expected 00812203", out_inst); end
        if (out_addr !== 8'h02) begin n_fail++; $display("FAIL b2b_lw_addr: got %h expected 02", out_addr); end
        send(4'd8, 5'd7, 5'd1, 5'd5, -13'sd4, 1'b0);
        step();
        n_checks += 2;
        if (out_inst !== 32'hFE50AE23) begin n_fail++; $display("FAIL b2b_sw_inst: got %h expected fe50ae23", out_inst); end
        if (out_addr !== 8'h03) begin n_fail++; $display("FAIL b2b_sw_addr: got %h expected 03", out_addr); end
        send(4'd9, 5'd3, 5'd1, 5'd2, -13'sd8, 1'b1);
        step();
        idle_in();
        n_checks += 3;
        if (out_inst !== 32'hFE208CE3) begin n_fail++; $display("FAIL b2b_beq_inst: got %h expected fe208ce3", out_inst); end
        if (out_addr !== 8'h04) begin n_fail++; $display("FAIL b2b_beq_addr: got %h expected 04", out_addr); end
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_drain_ready: got %b expected 0", in_ready); end
        wait_done("b2b");
    endtask

    task automatic test_backpressure;
        pulse_start();
        out_ready = 1'b0;
        send(4'd0, 5'd3, 5'd1, 5'd2, 13'sd0, 1'b0);
        step();
        send(4'd3, 5'd1, 5'd2, 5'd3, 13'sd0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            n_checks += 4;
            if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid[%0d]: got %b expected 1", i, out_valid); end
            if (out_inst !== 32'h002081B3) begin n_fail++; $display("FAIL bp_inst[%0d]: got %h expected 002081b3", i, out_inst); end
            if (out_addr !== 8'h00) begin n_fail++; $display("FAIL bp_addr[%0d]: got %h expected 00", i, out_addr); end
            if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready[%0d]: got %b expected 0", i, in_ready); end
            step();
        end
        out_ready = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready: got %b expected 1", in_ready); end
        step();
        idle_in();
        n_checks += 3;
        if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_or_valid: got %b expected 1", out_valid); end
        if (out_inst !== 32'h003160B3) begin n_fail++; $display("FAIL bp_or_inst: got %h expected 003160b3", out_inst); end
        if (out_addr !== 8'h01) begin n_fail++; $display("FAIL bp_or_addr: got %h expected 01", out_addr); end
        wait_done("bp");
        n_checks++;
        if (out_addr !== 8'h02) begin n_fail++; $display("FAIL bp_final_addr: got %h expected 02", out_addr); end
    endtask

    task automatic test_errors;
        pulse_start();
        send(4'd12, 5'd1, 5'd2, 5'd3, 13'sd0, 1'b0);
        step();
        n_checks += 3;
        if (err !== 1'b1) begin n_fail++; $display("FAIL err_illop_err: got %b expected 1", err); end
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL err_illop_valid: got %b expected 0", out_valid); end
        if (out_addr !== 8'h00) begin n_fail++; $display("FAIL err_illop_addr: got %h expected 00", out_addr); end
        send(4'd4, 5'd1, 5'd0, 5'd0, 13'sd3000, 1'b0);
        step();
        n_checks += 2;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL err_imm_valid: got %b expected 0", out_valid); end
        if (out_addr !== 8'h00) begin n_fail++; $display("FAIL err_imm_addr: got %h expected 00", out_addr); end
        send(4'd9, 5'd0, 5'd1, 5'd2, 13'sd5, 1'b0);
        step();
        n_checks += 2;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL err_odd_valid: got %b expected 0", out_valid); end
        if (out_addr !== 8'h00) begin n_fail++; $display("FAIL err_odd_addr: got %h expected 00", out_addr); end
        send(4'd0, 5'd3, 5'd1, 5'd2, 13'sd0, 1'b0);
        step();
        n_checks += 4;
        if (out_valid !== 1'b1) begin n_fail++; $display("FAIL err_add_valid: got %b expected 1", out_valid); end
        if (out_inst !== 32'h002081B3) begin n_fail++; $display("FAIL err_add_inst: got %h expected 002081b3", out_inst); end
        if (out_addr !== 8'h00) begin n_fail++; $display("FAIL err_add_addr: got %h expected 00", out_addr); end
        if (err !== 1'b1) begin n_fail++; $display("FAIL err_sticky: got %b expected 1", err); end
        send(4'd4, 5'd1, 5'd0, 5'd0, 13'sd2047, 1'b0);
        step();
        n_checks += 2;
        if (out_inst !== 32'h7FF00093) begin n_fail++; $display("FAIL err_imm_max_inst: got %h expected 7ff00093", out_inst); end
        if (out_addr !== 8'h01) begin n_fail++; $display("FAIL err_imm_max_addr: got %h expected 01", out_addr); end
        send(4'd4, 5'd1, 5'd0, 5'd0, -13'sd2048, 1'b0);
        step();
        n_checks += 2;
        if (out_inst !== 32'h80000093) begin n_fail++; $display("FAIL err_imm_min_inst: got %h expected 80000093", out_inst); end
        if (out_addr !== 8'h02) begin n_fail++; $display("FAIL err_imm_min_addr: got %h expected 02", out_addr); end
        send(4'd8, 5'd0, 5'd1, 5'd5, 13'sd2048, 1'b0);
        step();
        n_checks += 2;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL err_sw_range_valid: got %b expected 0", out_valid); end
        if (out_addr !== 8'h03) begin n_fail++; $display("FAIL err_sw_range_addr: got %h expected 03", out_addr); end
        send(4'd15, 5'd0, 5'd0, 5'd0, 13'sd0, 1'b1);
        step();
        idle_in();
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL err_last_valid: got %b expected 0", out_valid); end
        wait_done("err_last");
        n_checks += 2;
        if (err !== 1'b1) begin n_fail++; $display("FAIL err_at_done: got %b expected 1", err); end
        if (out_addr !== 8'h03) begin n_fail++; $display("FAIL err_done_addr: got %h expected 03", out_addr); end
        pulse_start();
        n_checks += 3;
        if (err !== 1'b0) begin n_fail++; $display("FAIL err_clear_on_start: got %b expected 0", err); end
        if (done !== 1'b0) begin n_fail++; $display("FAIL done_clear_on_start: got %b expected 0", done); end
        if (out_addr !== 8'h00) begin n_fail++; $display("FAIL addr_on_restart: got %h expected 00", out_addr); end
    endtask

    task automatic test_wrap_and_reset;
        logic [31:0] exp_inst;
        out_ready = 1'b1;
        start2 = 1'b1;
        step();
        start2 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            send(4'd0, 5'(i + 1), 5'd1, 5'd2, 13'sd0, 1'b0);
            step();
            exp_inst = {7'b0000000, 5'd2, 5'd1, 3'b000, 5'(i + 1), 7'b0110011};
            n_checks += 3;
            if (out_valid2 !== 1'b1) begin n_fail++; $display("FAIL wrap_valid[%0d]: got %b expected 1", i, out_valid2); end
            if (out_inst2 !== exp_inst) begin n_fail++; $display("FAIL wrap_inst[%0d]: got %h expected %h", i, out_inst2, exp_inst); end
            if (out_addr2 !== 2'(i)) begin n_fail++; $display("FAIL wrap_addr[%0d]: got %0d expected %0d", i, out_addr2, i % 4); end
            if (i == 3) begin
                n_checks++;
                if (err2 !== 1'b0) begin n_fail++; $display("FAIL wrap_err_early: got %b expected 0", err2); end
            end
            if (i == 4) begin
                n_checks++;
                if (err2 !== 1'b1) begin n_fail++; $display("FAIL wrap_err_set: got %b expected 1", err2); end
            end
        end
        rst2 = 1'b1;
        step();
        n_checks += 6;
        if (out_valid2 !== 1'b0) begin n_fail++; $display("FAIL midrst_valid: got %b expected 0", out_valid2); end
        if (out_inst2 !== 32'h0) begin n_fail++; $display("FAIL midrst_inst: got %h expected 0", out_inst2); end
        if (out_addr2 !== 2'd0) begin n_fail++; $display("FAIL midrst_addr: got %0d expected 0", out_addr2); end
        if (err2 !== 1'b0) begin n_fail++; $display("FAIL midrst_err: got %b expected 0", err2); end
        if (done2 !== 1'b0) begin n_fail++; $display("FAIL midrst_done: got %b expected 0", done2); end
        if (in_ready2 !== 1'b0) begin n_fail++; $display("FAIL midrst_ready: got %b expected 0", in_ready2); end
        rst2 = 1'b0;
        idle_in();
        step();
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_errors();
        test_wrap_and_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
